// File: rtl/cla_multiword_seq.sv
// Sequences a (32*WORDS)-bit add through an external 32-bit CLA, one slice per cycle, LSW first.
// Optional macro CLA_SEQ_SUB_EN adds a 'sub' input selecting A - B.
module cla_multiword_seq #(
   parameter int unsigned WORDS = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
`ifdef CLA_SEQ_SUB_EN
   input  logic                  sub,
`endif
   input  logic                  start,
   input  logic [32*WORDS-1:0]   op_a,
   input  logic [32*WORDS-1:0]   op_b,
   input  logic                  cin,
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic [32*WORDS-1:0]   result,
   output logic                  cout,
   output logic [31:0]           adder_a,
   output logic [31:0]           adder_b,
   output logic                  adder_cin,
   input  logic [31:0]           adder_sum,
   input  logic                  adder_cout
);

   localparam int unsigned W     = 32 * WORDS;
   localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nx;
   logic [IDX_W-1:0]   idx;
   logic               carry_reg;
   logic [W-1:0]       a_reg;
   logic [W-1:0]       b_reg;
   logic               sub_reg;
   logic               accept;
   logic               last_slice;
   logic [31:0]        b_slice;

   assign accept     = (state == IDLE) && start;
   assign last_slice = (idx == IDX_LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last_slice) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Adder drive: current slice while running, zero otherwise
   always_comb begin
      adder_a   = '0;
      adder_b   = '0;
      adder_cin = 1'b0;
      b_slice   = b_reg[32*idx +: 32];
      if (state == RUN) begin
         adder_a   = a_reg[32*idx +: 32];
         adder_b   = sub_reg ? ~b_slice : b_slice;
         adder_cin = carry_reg;
      end
   end

   // Operand capture and slice-by-slice accumulation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         carry_reg <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         sub_reg   <= 1'b0;
         result    <= '0;
         cout      <= 1'b0;
      end else if (accept) begin
         idx   <= '0;
         a_reg <= op_a;
         b_reg <= op_b;
`ifdef CLA_SEQ_SUB_EN
         sub_reg   <= sub;
         carry_reg <= sub ? 1'b1 : cin;
`else
         sub_reg   <= 1'b0;
         carry_reg <= cin;
`endif
      end else if (state == RUN) begin
         result[32*idx +: 32] <= adder_sum;
         carry_reg            <= adder_cout;
         if (last_slice) begin
            cout <= adder_cout;
         end else begin
            idx <= idx + IDX_W'(1);
         end
      end
   end

   // Handshake flags follow the next state so they line up with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         ready <= (state_nx == IDLE);
         busy  <= (state_nx == RUN);
         done  <= (state_nx == DONE);
      end
   end

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Directed and random checks of cla_multiword_seq (WORDS=2 and WORDS=4) with a behavioural 32-bit adder.
module tb_cla_multiword_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // WORDS = 2 instance
   logic         start = 1'b0;
   logic [63:0]  op_a = '0, op_b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         ready, busy, done, cout;
   logic [63:0]  result;
   logic [31:0]  adder_a, adder_b, adder_sum;
   logic         adder_cin, adder_cout;

   assign {adder_cout, adder_sum} = 33'(adder_a) + 33'(adder_b) + 33'(adder_cin);

   cla_multiword_seq #(.WORDS(2)) u2 (
      .clk(clk), .rst_n(rst_n),
`ifdef CLA_SEQ_SUB_EN
      .sub(sub),
`endif
      .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
      .ready(ready), .busy(busy), .done(done), .result(result), .cout(cout),
      .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
      .adder_sum(adder_sum), .adder_cout(adder_cout)
   );

   // WORDS = 4 instance
   logic         start4 = 1'b0;
   logic [127:0] op_a4 = '0, op_b4 = '0;
   logic         cin4 = 1'b0;
   logic         sub4 = 1'b0;
   logic         ready4, busy4, done4, cout4;
   logic [127:0] result4;
   logic [31:0]  adder_a4, adder_b4, adder_sum4;
   logic         adder_cin4, adder_cout4;

   assign {adder_cout4, adder_sum4} = 33'(adder_a4) + 33'(adder_b4) + 33'(adder_cin4);

   cla_multiword_seq #(.WORDS(4)) u4 (
      .clk(clk), .rst_n(rst_n),
`ifdef CLA_SEQ_SUB_EN
      .sub(sub4),
`endif
      .start(start4), .op_a(op_a4), .op_b(op_b4), .cin(cin4),
      .ready(ready4), .busy(busy4), .done(done4), .result(result4), .cout(cout4),
      .adder_a(adder_a4), .adder_b(adder_b4), .adder_cin(adder_cin4),
      .adder_sum(adder_sum4), .adder_cout(adder_cout4)
   );

   logic cin_s0, cin_s1;

   task automatic chk(input logic [127:0] obs, input logic [127:0] exp, input string tag);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full WORDS=2 operation with latency, result and done-width checks
   task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic c,
                        input logic [63:0] er, input logic ec, input string tag);
      int lat;
      @(negedge clk);
      op_a = a; op_b = b; cin = c; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      op_a = ~a; op_b = ~b; cin = ~c;
      cin_s0 = adder_cin;
      chk(64'(busy), 64'd1, {tag, "_busy"});
      lat = 0;
      while (!done && lat < 10) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) cin_s1 = adder_cin;
      end
      chk(128'(lat), 128'd2, {tag, "_lat"});
      chk(128'(result), 128'(er), {tag, "_result"});
      chk(128'(cout), 128'(ec), {tag, "_cout"});
      @(posedge clk); #1;
      chk(128'({done, ready, busy}), 128'(3'b010), {tag, "_after"});
      chk(128'({adder_a, adder_b, adder_cin}), 128'd0, {tag, "_idle_adder"});
   endtask

   initial begin
      logic [63:0]  va [3];
      logic [63:0]  vb [3];
      logic [63:0]  vr [3];
      logic         vc [3];
      logic [64:0]  s65;
      logic [128:0] s129;
      logic [63:0]  ra, rb;
      logic         rc;
      int nacc, ndone, lat;
      logic seen_done;

      // Reset state
      #12;
      chk(128'({ready, busy, done, cout}), 128'(4'b1000), "rst_flags");
      chk(128'(result), 128'd0, "rst_result");
      chk(128'({adder_a, adder_b, adder_cin}), 128'd0, "rst_adder");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk(128'(ready), 128'd1, "ready_after_rst");

      // Carry crosses the slice boundary
      do_op(64'h00000000_FFFFFFFF, 64'd1, 1'b0, 64'h00000001_00000000, 1'b0, "cross");
      chk(128'(cin_s0), 128'd0, "cross_cin_s0");
      chk(128'(cin_s1), 128'd1, "cross_cin_s1");

      do_op(64'hFFFFFFFF_FFFFFFFF, 64'd1, 1'b0, 64'd0, 1'b1, "wrap");
      do_op(64'd0, 64'd0, 1'b1, 64'd1, 1'b0, "cin_only");

      // start held high across three operations
      va[0] = 64'd5;                 vb[0] = 64'd7;                 vr[0] = 64'd12;                 vc[0] = 1'b0;
      va[1] = 64'hFFFFFFFF_FFFFFFFF; vb[1] = 64'd1;                 vr[1] = 64'd0;                  vc[1] = 1'b1;
      va[2] = 64'h12345678_9ABCDEF0; vb[2] = 64'h11111111_11111111; vr[2] = 64'h23456789_ABCDF001; vc[2] = 1'b0;
      nacc = 0; ndone = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         start = 1'b1; cin = 1'b0;
         if (ready && nacc < 3) begin
            op_a = va[nacc]; op_b = vb[nacc]; nacc++;
         end else begin
            op_a = 64'(k) * 64'h01010101_01010101; op_b = ~op_a;
         end
         @(posedge clk); #1;
         if (done) begin
            if (ndone < 3) begin
               chk(128'(result), 128'(vr[ndone]), "stream_result");
               chk(128'(cout), 128'(vc[ndone]), "stream_cout");
            end
            ndone++;
         end
      end
      start = 1'b0;
      chk(128'(ndone), 128'd3, "stream_done_count");

      // Reset during the first RUN cycle discards the operation
      @(negedge clk);
      op_a = 64'd5; op_b = 64'd7; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk(128'(busy), 128'd1, "abort_busy");
      rst_n = 1'b0;
      #1;
      chk(128'({busy, done}), 128'd0, "abort_flags");
      chk(128'(result), 128'd0, "abort_result");
      seen_done = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done) seen_done = 1'b1;
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         if (done) seen_done = 1'b1;
      end
      chk(128'(seen_done), 128'd0, "abort_no_done");
      do_op(64'h00000002_80000000, 64'h00000003_80000000, 1'b1, 64'h00000006_00000001, 1'b0, "after_abort");

`ifdef CLA_SEQ_SUB_EN
      sub = 1'b1;
      do_op(64'd5, 64'd7, 1'b0, 64'hFFFFFFFF_FFFFFFFE, 1'b0, "sub_5_7");
      do_op(64'd7, 64'd5, 1'b0, 64'd2, 1'b1, "sub_7_5");
      do_op(64'd7, 64'd5, 1'b1, 64'd2, 1'b1, "sub_cin_ignored");
      sub = 1'b0;
`endif

      // Random WORDS=2 against the 64-bit reference sum
      for (int i = 0; i < 200; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         rc = 1'($urandom);
         s65 = 65'(ra) + 65'(rb) + 65'(rc);
         do_op(ra, rb, rc, s65[63:0], s65[64], "rand2");
      end

      // Random WORDS=4 against the 128-bit reference sum
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         op_a4 = {$urandom, $urandom, $urandom, $urandom};
         op_b4 = (i % 4 == 0) ? ~op_a4 : {$urandom, $urandom, $urandom, $urandom};
         cin4  = 1'($urandom);
         s129  = 129'(op_a4) + 129'(op_b4) + 129'(cin4);
         start4 = 1'b1;
         @(posedge clk); #1;
         start4 = 1'b0;
         op_a4 = '0; op_b4 = '0;
         lat = 0;
         while (!done4 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
         end
         chk(128'(lat), 128'd4, "rand4_lat");
         chk(result4, s129[127:0], "rand4_result");
         chk(128'(cout4), 128'(s129[128]), "rand4_cout");
         @(posedge clk); #1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
